// File: rtl/multi_motor_guard.sv
// rtl/multi_motor_guard.sv - NUM_CH-channel H-bridge steering guard with trip, cooldown, dead-time and lockout
// Build option: define OC_FILTER_EN to require OVER1 on two consecutive ticks before a trip.
module multi_motor_guard #(
    parameter int NUM_CH     = 2,
    parameter int DIV_BITS   = 11,
    parameter int DEAD_TICKS = 4,
    parameter int COOL_TICKS = 16,
    parameter int MAX_TRIPS  = 3
) (
    input  logic              CLK_100MHz,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] PWM_IN,
    input  logic [NUM_CH-1:0] DIR,
    input  logic [NUM_CH-1:0] OVER1,
    input  logic [NUM_CH-1:0] UNDER750,
    input  logic              CLEAR,
    output logic [NUM_CH-1:0] FORWARD,
    output logic [NUM_CH-1:0] BACKWARD,
    output logic [NUM_CH-1:0] SNS,
    output logic [NUM_CH-1:0] FAULT
);

    localparam int TMAX = (DEAD_TICKS > COOL_TICKS) ? DEAD_TICKS : COOL_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_TICKS - 1);
    localparam logic [TW-1:0] COOL_LOAD = TW'(COOL_TICKS - 1);
    localparam logic [3:0]    TRIP_MAX  = 4'(MAX_TRIPS);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DEAD,
        ST_TRIP,
        ST_COOL,
        ST_LOCK
    } state_t;

    logic [DIV_BITS-1:0] div_q;
    logic                tick;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [3:0]        cnt_q   [NUM_CH];
    logic [3:0]        cnt_d   [NUM_CH];
    logic [TW-1:0]     tmr_q   [NUM_CH];
    logic [TW-1:0]     tmr_d   [NUM_CH];
    logic [NUM_CH-1:0] dir_q, dir_d;
    logic [NUM_CH-1:0] sns_q, sns_d;
    logic [NUM_CH-1:0] oc_trip;
    logic [NUM_CH-1:0] run_st, lock_st;

    assign tick = &div_q;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

`ifdef OC_FILTER_EN
    logic [NUM_CH-1:0] hist_q;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            hist_q <= '0;
        end else if (tick) begin
            hist_q <= OVER1;
        end
    end

    assign oc_trip = OVER1 & hist_q;
`else
    assign oc_trip = OVER1;
`endif

    // CLEAR acts every cycle; the tick-gated trip below sees the cleared count, so a coincident trip lands at 1.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            cnt_d[i]   = CLEAR ? 4'd0 : cnt_q[i];
            dir_d[i]   = dir_q[i];
            sns_d[i]   = sns_q[i];

            if (CLEAR && state_q[i] == ST_LOCK) begin
                state_d[i] = ST_TRIP;
            end

            if (tick) begin
                sns_d[i] = OVER1[i];
                if (state_q[i] != ST_LOCK && oc_trip[i]) begin
                    if (cnt_d[i] != TRIP_MAX) begin
                        cnt_d[i] = cnt_d[i] + 4'd1;
                    end
                    state_d[i] = (cnt_d[i] == TRIP_MAX) ? ST_LOCK : ST_TRIP;
                end else begin
                    case (state_q[i])
                        ST_RUN: begin
                            if (DIR[i] != dir_q[i]) begin
                                state_d[i] = ST_DEAD;
                                tmr_d[i]   = DEAD_LOAD;
                            end
                        end
                        ST_DEAD: begin
                            if (tmr_q[i] == '0) begin
                                dir_d[i]   = DIR[i];
                                state_d[i] = ST_RUN;
                            end else begin
                                tmr_d[i] = tmr_q[i] - 1'b1;
                            end
                        end
                        ST_TRIP: begin
                            if (UNDER750[i]) begin
                                state_d[i] = ST_COOL;
                                tmr_d[i]   = COOL_LOAD;
                            end
                        end
                        ST_COOL: begin
                            if (!UNDER750[i]) begin
                                state_d[i] = ST_TRIP;
                            end else if (tmr_q[i] == '0) begin
                                // Bridge has been off throughout, so no dead-time on direction pickup.
                                dir_d[i]   = DIR[i];
                                state_d[i] = ST_RUN;
                            end else begin
                                tmr_d[i] = tmr_q[i] - 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
                tmr_q[i]   <= '0;
            end
            dir_q <= '0;
            sns_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
            dir_q <= dir_d;
            sns_q <= sns_d;
        end
    end

    always_comb begin
        run_st  = '0;
        lock_st = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_st[i]  = (state_q[i] == ST_RUN);
            lock_st[i] = (state_q[i] == ST_LOCK);
        end
    end

    // RESET_N gates the legs so the bridge is off while reset is held, even though the reset state is RUN.
    assign FORWARD  = PWM_IN & run_st & ~dir_q & {NUM_CH{RESET_N}};
    assign BACKWARD = PWM_IN & run_st &  dir_q & {NUM_CH{RESET_N}};
    assign SNS      = sns_q;
    assign FAULT    = lock_st;

endmodule

// File: tb/tb_multi_motor_guard.sv
// tb/tb_multi_motor_guard.sv - directed self-checking bench for multi_motor_guard
module tb_multi_motor_guard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pwm, dir, over1, under;
    logic       clear;
    logic [1:0] fwd, bwd, sns, fault;
    logic [1:0] tb_div;
    int         errors = 0;
    int         checks = 0;

    multi_motor_guard #(
        .NUM_CH(2), .DIV_BITS(2), .DEAD_TICKS(2), .COOL_TICKS(3), .MAX_TRIPS(2)
    ) dut (
        .CLK_100MHz(clk),
        .RESET_N   (rst_n),
        .PWM_IN    (pwm),
        .DIR       (dir),
        .OVER1     (over1),
        .UNDER750  (under),
        .CLEAR     (clear),
        .FORWARD   (fwd),
        .BACKWARD  (bwd),
        .SNS       (sns),
        .FAULT     (fault)
    );

    always #5 clk = ~clk;

    // Tick phase as defined by the divider: tick on the cycle where the count is all-ones.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_div <= 2'd0;
        else        tb_div <= tb_div + 2'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic next_tick();
        bit last;
        for (int n = 0; n < 8; n++) begin
            last = (tb_div == 2'd3);
            @(posedge clk);
            #1;
            if (last) return;
        end
        checks++;
        errors++;
        $display("FAIL tick_sync: got no tick within 8 cycles, expected one");
    endtask

    task automatic trip_pulse(input logic [1:0] ch, input logic clr);
        over1 = ch;
        clear = clr;
`ifdef OC_FILTER_EN
        next_tick();
`endif
        next_tick();
        over1 = 2'b00;
        clear = 1'b0;
`ifdef OC_FILTER_EN
        next_tick();
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pwm   = 2'b11;
        dir   = 2'b00;
        over1 = 2'b00;
        under = 2'b00;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm   = 2'b11;
        dir   = 2'b00;
        over1 = 2'b00;
        under = 2'b00;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fwd, bwd, sns, fault} !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got %b expected %b", {fwd, bwd, sns, fault}, 8'h00);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fwd, bwd, fault} !== 6'b11_00_00) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", {fwd, bwd, fault}, 6'b11_00_00);
        end
        pwm = 2'b01;
        #1;
        checks++;
        if (fwd !== 2'b01) begin
            errors++;
            $display("FAIL pwm_follow: got %b expected %b", fwd, 2'b01);
        end
        pwm = 2'b11;
        #1;
    endtask

    task automatic test_dead_time();
        dir = 2'b01;
        next_tick();
        checks++;
        if ({fwd, bwd} !== 4'b10_00) begin
            errors++;
            $display("FAIL dead_tick1: got %b expected %b", {fwd, bwd}, 4'b10_00);
        end
        next_tick();
        checks++;
        if ({fwd, bwd} !== 4'b10_00) begin
            errors++;
            $display("FAIL dead_tick2: got %b expected %b", {fwd, bwd}, 4'b10_00);
        end
        next_tick();
        checks++;
        if ({fwd, bwd} !== 4'b10_01) begin
            errors++;
            $display("FAIL dead_exit: got %b expected %b", {fwd, bwd}, 4'b10_01);
        end
    endtask

    task automatic test_trip_cool();
        trip_pulse(2'b01, 1'b0);
        checks++;
        if ({fwd, bwd, fault} !== 6'b10_00_00) begin
            errors++;
            $display("FAIL trip1: got %b expected %b", {fwd, bwd, fault}, 6'b10_00_00);
        end
        under = 2'b01;
        next_tick();
        under = 2'b00;
        next_tick();
        under = 2'b01;
        next_tick();
        next_tick();
        next_tick();
        checks++;
        if (bwd !== 2'b00) begin
            errors++;
            $display("FAIL cool_hold: got %b expected %b", bwd, 2'b00);
        end
        next_tick();
        checks++;
        if ({fwd, bwd} !== 4'b10_01) begin
            errors++;
            $display("FAIL cool_resume: got %b expected %b", {fwd, bwd}, 4'b10_01);
        end
    endtask

    task automatic test_lockout();
        trip_pulse(2'b01, 1'b0);
        checks++;
        if ({bwd, fault} !== 4'b00_01) begin
            errors++;
            $display("FAIL lock_enter: got %b expected %b", {bwd, fault}, 4'b00_01);
        end
        next_tick();
        next_tick();
        checks++;
        if ({bwd, fault} !== 4'b00_01) begin
            errors++;
            $display("FAIL lock_hold: got %b expected %b", {bwd, fault}, 4'b00_01);
        end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checks++;
        if ({bwd, fault} !== 4'b00_00) begin
            errors++;
            $display("FAIL clear_unlock: got %b expected %b", {bwd, fault}, 4'b00_00);
        end
        next_tick();
        next_tick();
        next_tick();
        checks++;
        if (bwd !== 2'b00) begin
            errors++;
            $display("FAIL clear_cool: got %b expected %b", bwd, 2'b00);
        end
        next_tick();
        checks++;
        if ({fwd, bwd} !== 4'b10_01) begin
            errors++;
            $display("FAIL clear_resume: got %b expected %b", {fwd, bwd}, 4'b10_01);
        end
        trip_pulse(2'b01, 1'b0);
        checks++;
        if (fault !== 2'b00) begin
            errors++;
            $display("FAIL cnt_cleared: got %b expected %b", fault, 2'b00);
        end
        trip_pulse(2'b01, 1'b1);
        checks++;
        if (fault !== 2'b00) begin
            errors++;
            $display("FAIL clear_vs_trip: got %b expected %b", fault, 2'b00);
        end
        trip_pulse(2'b01, 1'b0);
        checks++;
        if (fault !== 2'b01) begin
            errors++;
            $display("FAIL clear_vs_trip_cnt: got %b expected %b", fault, 2'b01);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        over1 = 2'b01;
        next_tick();
        over1 = 2'b00;
        checks++;
        if (sns !== 2'b01) begin
            errors++;
            $display("FAIL glitch_sns: got %b expected %b", sns, 2'b01);
        end
`ifdef OC_FILTER_EN
        checks++;
        if (fwd !== 2'b11) begin
            errors++;
            $display("FAIL glitch_filtered: got %b expected %b", fwd, 2'b11);
        end
`else
        checks++;
        if (fwd !== 2'b10) begin
            errors++;
            $display("FAIL glitch_trip: got %b expected %b", fwd, 2'b10);
        end
`endif
        next_tick();
        checks++;
        if (sns !== 2'b00) begin
            errors++;
            $display("FAIL sns_clear: got %b expected %b", sns, 2'b00);
        end
`ifdef OC_FILTER_EN
        over1 = 2'b01;
        next_tick();
        next_tick();
        over1 = 2'b00;
        checks++;
        if (fwd !== 2'b10) begin
            errors++;
            $display("FAIL filter_two_tick: got %b expected %b", fwd, 2'b10);
        end
`endif
        over1 = 2'b10;
        under = 2'b10;
        next_tick();
        next_tick();
        over1 = 2'b00;
        under = 2'b00;
`ifdef OC_FILTER_EN
        checks++;
        if ({fwd[1], fault[1]} !== 2'b00) begin
            errors++;
            $display("FAIL over_wins: got %b expected %b", {fwd[1], fault[1]}, 2'b00);
        end
`else
        checks++;
        if ({fwd[1], fault[1]} !== 2'b01) begin
            errors++;
            $display("FAIL over_wins: got %b expected %b", {fwd[1], fault[1]}, 2'b01);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        dir = 2'b01;
        next_tick();
        checks++;
        if (fwd !== 2'b10) begin
            errors++;
            $display("FAIL pre_reset_dead: got %b expected %b", fwd, 2'b10);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwd, bwd, sns, fault} !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_dead: got %b expected %b", {fwd, bwd, sns, fault}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dir   = 2'b00;
        #1;
        checks++;
        if ({fwd, bwd, fault} !== 6'b11_00_00) begin
            errors++;
            $display("FAIL run_after_dead_reset: got %b expected %b", {fwd, bwd, fault}, 6'b11_00_00);
        end
        over1 = 2'b10;
        next_tick();
        next_tick();
        next_tick();
        over1 = 2'b00;
        checks++;
        if ({fwd, fault} !== 4'b01_10) begin
            errors++;
            $display("FAIL pre_reset_lock: got %b expected %b", {fwd, fault}, 4'b01_10);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fwd, bwd, sns, fault} !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_lock: got %b expected %b", {fwd, bwd, sns, fault}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({fwd, bwd, fault} !== 6'b11_00_00) begin
            errors++;
            $display("FAIL run_after_lock_reset: got %b expected %b", {fwd, bwd, fault}, 6'b11_00_00);
        end
    endtask

    initial begin
        test_reset();
        test_dead_time();
        test_trip_cool();
        test_lockout();
        test_glitch();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
